// File: rtl/program_loader.sv
// program_loader: streams a host program into instruction memory while holding the CPU in reset
module program_loader #(
    parameter int ADDR_W   = 8,
    parameter int HOLD_CYC = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int HW   = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, len_q, len_d, addr_q, addr_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d, cpu_rst_q, cpu_rst_d, busy_q, busy_d;
    logic              done_q, done_d, error_q, error_d;
    logic              accept;

    assign in_ready   = state_q == LOAD;
    assign accept     = in_valid && in_ready;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

    // Next state, counters and registered outputs; CPU is released only after a full load plus the hold window
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        to_d    = to_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (start && len == '0) begin
                    error_d = 1'b1;
                end else if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    to_d    = '0;
                    len_d   = len;
                end
            end
            LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = in_data;
                    cnt_d   = cnt_q + ADDR_W'(1);
                    to_d    = '0;
                    if (cnt_q == len_q - ADDR_W'(1)) begin
                        state_d = RELEASE;
                        hold_d  = '0;
                    end
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            RELEASE: begin
                if (hold_q == HW'(HOLD_CYC - 1)) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        cpu_rst_d = state_d != RUN;
        busy_d    = state_d == LOAD || state_d == RELEASE;
    end

    // State and output registers; reset holds the CPU in reset and cancels any load in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            to_q      <= '0;
            hold_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            to_q      <= to_d;
            hold_q    <= hold_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized load sequences checked against a transaction-level expectation
module tb_program_loader;
    localparam int AW = 8;
    localparam int HOLD_CYC = 4;
    localparam int TIMEOUT = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_ready, imem_we, cpu_rst, busy, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_n = 0;
    int err_n = 0;
    int done_c = 0;
    int err_c = 0;
    int          wc[$];
    logic [AW-1:0] wa[$];
    logic [31:0] wd[$];
    logic        wr[$];
    logic        wi[$];

    program_loader #(.ADDR_W(AW), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Record every memory write and every done/error pulse with its cycle number
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_we) begin
            wc.push_back(cyc);
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            wr.push_back(cpu_rst);
            wi.push_back(in_ready);
        end
        if (done) begin
            done_n = done_n + 1;
            done_c = cyc;
        end
        if (error) begin
            err_n = err_n + 1;
            err_c = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic reject();
        logic cr;
        cr = cpu_rst;
        @(negedge clk);
        start = 1'b1;
        len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("rej_error", error, 1);
        @(negedge clk);
        chk("rej_error_pulse", error, 0);
        chk("rej_cpu_rst", cpu_rst, cr);
        chk("rej_busy", busy, 0);
        chk("rej_in_ready", in_ready, 0);
    endtask

    task automatic do_load(input int n, input logic [31:0] fixed[$], input int glo, input int ghi, input bit stray);
        logic [31:0] words[$];
        int w0, d0, e0, t, last;
        w0 = wa.size();
        d0 = done_n;
        e0 = err_n;
        for (int k = 0; k < n; k++) words.push_back(k < fixed.size() ? fixed[k] : $urandom);
        @(negedge clk);
        start = 1'b1;
        len = AW'(n);
        @(negedge clk);
        start = 1'b0;
        chk("load_cpu_rst", cpu_rst, 1);
        chk("load_busy", busy, 1);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(ghi, glo)) @(negedge clk);
            in_valid = 1'b1;
            in_data = words[k];
            if (stray && $urandom_range(1, 0) == 1) begin
                start = 1'b1;
                len = AW'($urandom);
            end
            chk("in_ready", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b0;
        end
        t = 0;
        while (done_n == d0 && t < HOLD_CYC + 8) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("done_count", done_n - d0, 1);
        chk("write_count", wa.size() - w0, n);
        for (int k = 0; k < n; k++) begin
            if (w0 + k < wa.size()) begin
                chk("write_addr", wa[w0+k], k);
                chk("write_data", wd[w0+k], words[k]);
                chk("write_cpu_rst", wr[w0+k], 1);
            end
        end
        if (wa.size() > w0) begin
            last = wa.size() - 1;
            chk("hold_cycles", done_c - wc[last], HOLD_CYC);
            chk("ready_drop", wi[last], 0);
            if (ghi == 0) chk("back_to_back", wc[last] - wc[w0], n - 1);
        end
        chk("load_no_error", err_n - e0, 0);
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_busy", busy, 0);
    endtask

    task automatic do_timeout();
        int w0, d0, e0;
        w0 = wa.size();
        d0 = done_n;
        e0 = err_n;
        @(negedge clk);
        start = 1'b1;
        len = AW'(2);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (TIMEOUT + 5) @(negedge clk);
        chk("to_writes", wa.size() - w0, 1);
        chk("to_error_count", err_n - e0, 1);
        chk("to_no_done", done_n - d0, 0);
        if (wa.size() > w0) chk("to_latency", err_c - wc[wa.size()-1], TIMEOUT);
        chk("to_cpu_rst", cpu_rst, 1);
        chk("to_busy", busy, 0);
        chk("to_in_ready", in_ready, 0);
    endtask

    task automatic do_abort();
        int w0, d0;
        w0 = wa.size();
        d0 = done_n;
        @(negedge clk);
        start = 1'b1;
        len = AW'(4);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = $urandom;
        @(negedge clk);
        in_data = $urandom;
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_writes", wa.size() - w0, 1);
        chk("abort_no_done", done_n - d0, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_cpu_rst", cpu_rst, 1);
    endtask

    initial begin
        logic [31:0] abc[$];
        logic [31:0] none[$];
        abc = '{32'hA, 32'hB, 32'hC};
        do_reset();
        reject();
        do_load(3, abc, 0, 0, 0);
        reject();
        do_load(1, none, 0, 0, 0);
        do_load(2, none, 5, 5, 0);
        for (int i = 0; i < 6; i++) begin
            int g;
            g = $urandom_range(3, 0);
            do_load($urandom_range(20, 1), none, 0, g, 1);
        end
        do_load(2, none, TIMEOUT - 1, TIMEOUT - 1, 0);
        do_timeout();
        reject();
        do_abort();
        do_load($urandom_range(8, 1), none, 0, 2, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 Parameter HOLD_CYC, default 4: cycles cpu_rst stays high after the last word is written.
REQ-003 Parameter TIMEOUT, default 1024: idle cycles allowed between words during a load.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request a program load; sampled on rising edge.
REQ-007 len  in  ADDR_W  number of words to load; sampled when start is accepted.
REQ-008 in_valid  in  1  host word valid.
REQ-009 in_data  in  32  host instruction word.
REQ-010 in_ready  out  1  loader can accept a word this cycle.
REQ-011 imem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-012 imem_addr  out  ADDR_W  instruction-memory word address.
REQ-013 imem_wdata  out  32  instruction-memory write data.
REQ-014 cpu_rst  out  1  active-high reset to the processor top (drives its rst).
REQ-015 busy  out  1  high in LOAD or RELEASE.
REQ-016 done  out  1  one-cycle pulse on the RELEASE->RUN transition.
REQ-017 error  out  1  one-cycle pulse on rejected start or timeout.

Function
REQ-018 FSM states: IDLE, LOAD, RELEASE, RUN; all outputs registered except in_ready, which is high only in LOAD.
REQ-019 IDLE: start=1 with len!=0 -> LOAD; word counter and address cleared to 0; timeout counter cleared.
REQ-020 IDLE: start=1 with len=0 -> error pulse next cycle, remain IDLE.
REQ-021 A word is accepted on an edge where in_valid=1 and in_ready=1; data is held by the host until accepted.
REQ-022 Accepted word k (0-based) -> next cycle imem_we=1, imem_addr=k, imem_wdata=word; imem_we=0 otherwise.
REQ-023 Word counter increments per accepted word; on acceptance of word len-1, LOAD -> RELEASE and in_ready drops the following cycle.
REQ-024 imem_addr does not wrap within a load (len <= 2^ADDR_W-1 by width).
REQ-025 LOAD: timeout counter increments each cycle without acceptance, clears on acceptance; reaching TIMEOUT -> error pulse, state IDLE, cpu_rst stays 1.
REQ-026 RELEASE: counts HOLD_CYC cycles with cpu_rst=1, then -> RUN with done=1 for one cycle and cpu_rst=0 from that same cycle.
REQ-027 RUN: cpu_rst=0; start=1 with len!=0 -> LOAD with cpu_rst=1 next cycle (reload); start with len=0 -> error pulse, remain RUN.
REQ-028 start is ignored in LOAD and RELEASE; in_valid is ignored outside LOAD.
REQ-029 start and the final-word acceptance in the same cycle: final-word acceptance wins; start ignored.
REQ-030 cpu_rst=1 in IDLE, LOAD, RELEASE; the processor never runs from a partially loaded memory.

Reset
REQ-031 rst=1 forces immediately (asynchronously): state IDLE, counters 0, cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0.
REQ-032 rst during LOAD aborts the load; no imem_we is issued after rst asserts; a new start is required.

Verification
REQ-033 Reset, start with len=3, words 0xA, 0xB, 0xC with in_valid held high -> imem_we on 3 consecutive cycles at addr 0,1,2 with data 0xA,0xB,0xC; cpu_rst falls 4 cycles after RELEASE entry with a done pulse.
REQ-034 len=2, host inserts 5 idle cycles between words -> exactly 2 writes, addr 0 and 1, no error.
REQ-035 len=2, one word sent then in_valid=0 for 1024 cycles -> single error pulse, state IDLE, cpu_rst=1, no done.
REQ-036 start with len=0 in IDLE and in RUN -> error pulse, no state change, cpu_rst unchanged.
REQ-037 In RUN, start with len=1 -> cpu_rst=1 next cycle, one write at addr 0, done pulse, cpu_rst=0 again.
REQ-038 rst pulse after word 1 of a len=4 load -> all outputs at reset values immediately, no further imem_we.
